// File: rtl/btn_debounce.sv
// btn_debounce: per-button synchroniser and debouncer for the calculator's
// C/L/R push buttons. Each channel has a 2-flop synchroniser feeding a small
// FSM. The FSM accepts a level change only after DEBOUNCE_CYCLES consecutive
// synchronised samples at the new level. It outputs a clean level and a
// one-cycle press strobe.
//
// Optional build macro: BTN_RELEASE_PULSE_EN
//   When defined, the module adds an o_release port. It carries a one-cycle
//   strobe for each accepted release (1->0). When undefined, the port and its
//   logic do not exist.
//
// Sizing notes:
//   DEBOUNCE_CYCLES must be at least 2.
//   CNT_LEN must be wide enough that 2**CNT_LEN > DEBOUNCE_CYCLES.
//   Reset is synchronous and active-high.

module btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_LEN         = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
`ifdef BTN_RELEASE_PULSE_EN
  output logic [N_BTN-1:0] o_release,
`endif
  output logic [N_BTN-1:0] o_pulse
);

  // The terminal count is DEBOUNCE_CYCLES-1. A change is accepted on the
  // DEBOUNCE_CYCLES-th consecutive sample at the new level, because the first
  // such sample already loads the counter with 1.
  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_LEN-1:0] CNT_ONE  = CNT_LEN'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } debState_t;

  for (genvar g = 0; g < N_BTN; g++) begin : gChan

    logic               syncMeta;
    logic               syncOut;
    debState_t          state;
    logic [CNT_LEN-1:0] cnt;
    logic               levelReg;
    logic               pulseReg;
`ifdef BTN_RELEASE_PULSE_EN
    logic               releaseReg;
`endif

    // Two-flop synchroniser bringing the asynchronous button level into i_clk
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        syncMeta <= 1'b0;
        syncOut  <= 1'b0;
      end else begin
        syncMeta <= i_btn[g];
        syncOut  <= syncMeta;
      end
    end

    // Debounce FSM: qualify each level change by a run of identical samples
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        state      <= IDLE_LOW;
        cnt        <= '0;
        levelReg   <= 1'b0;
        pulseReg   <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
        releaseReg <= 1'b0;
`endif
      end else begin
        pulseReg   <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
        releaseReg <= 1'b0;
`endif
        case (state)
          IDLE_LOW: begin
            if (syncOut) begin
              state <= WAIT_HIGH;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_HIGH: begin
            if (!syncOut) begin
              state <= IDLE_LOW;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= IDLE_HIGH;
              levelReg <= 1'b1;
              pulseReg <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!syncOut) begin
              state <= WAIT_LOW;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_LOW: begin
            if (syncOut) begin
              state <= IDLE_HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= IDLE_LOW;
              levelReg <= 1'b0;
              cnt      <= '0;
`ifdef BTN_RELEASE_PULSE_EN
              releaseReg <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state    <= IDLE_LOW;
            cnt      <= '0;
            levelReg <= 1'b0;
          end
        endcase
      end
    end

    assign o_level[g]   = levelReg;
    assign o_pulse[g]   = pulseReg;
`ifdef BTN_RELEASE_PULSE_EN
    assign o_release[g] = releaseReg;
`endif

  end : gChan

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized and scenario-driven bench for btn_debounce.
// A reference model predicts the outputs every cycle, and directed scenarios
// add latency and pulse-count checks.
// The bench supports both builds; the optional build is selected with
// BTN_RELEASE_PULSE_EN.

module tb_btn_debounce;

  localparam int N_BTN = 3;
  localparam int DEB   = 4;
  localparam int CLEN  = 3;

  logic             i_clk;
  logic             i_reset;
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_pulse;
`ifdef BTN_RELEASE_PULSE_EN
  logic [N_BTN-1:0] o_release;
`endif

  btn_debounce #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_LEN        (CLEN)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_btn    (i_btn),
    .o_level  (o_level),
`ifdef BTN_RELEASE_PULSE_EN
    .o_release(o_release),
`endif
    .o_pulse  (o_pulse)
  );

  // Free-running 10-time-unit clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int compareCount = 0;
  int mismatchCount = 0;
  int cycleCnt = 0;

  // Reference model state.
  // The queue holds the two raw samples that are still in flight through
  // the synchroniser. runLen counts consecutive synchronised samples that
  // disagree with the accepted level.
  logic [N_BTN-1:0] pipeQ[$];
  int               runLen[N_BTN];
  logic [N_BTN-1:0] expLevel;
  logic [N_BTN-1:0] expPulse;
  logic [N_BTN-1:0] expRelease;

  // Scenario tracking of observed strobes and falling levels
  int               pulseCount[N_BTN];
  int               firstPulse[N_BTN];
  int               firstRelease[N_BTN];
  int               fallEdge[N_BTN];
  logic [N_BTN-1:0] prevLevel;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycleCnt, obs, exp);
    end
  endtask

  task automatic modelReset();
    pipeQ = '{'0, '0};
    expLevel = '0;
    expPulse = '0;
    expRelease = '0;
    for (int i = 0; i < N_BTN; i++) runLen[i] = 0;
  endtask

  task automatic modelStep();
    logic [N_BTN-1:0] s;
    expPulse = '0;
    expRelease = '0;
    if (i_reset) begin
      modelReset();
    end else begin
      s = pipeQ.pop_front();
      pipeQ.push_back(i_btn);
      for (int i = 0; i < N_BTN; i++) begin
        if (s[i] != expLevel[i]) begin
          runLen[i]++;
          if (runLen[i] == DEB) begin
            expLevel[i] = s[i];
            runLen[i] = 0;
            if (s[i]) expPulse[i] = 1'b1;
            else      expRelease[i] = 1'b1;
          end
        end else begin
          runLen[i] = 0;
        end
      end
    end
  endtask

  task automatic clearTracking();
    for (int i = 0; i < N_BTN; i++) begin
      pulseCount[i] = 0;
      firstPulse[i] = -1;
      firstRelease[i] = -1;
      fallEdge[i] = -1;
    end
  endtask

  task automatic observe();
    checkOutput("level", 32'(o_level), 32'(expLevel));
    checkOutput("pulse", 32'(o_pulse), 32'(expPulse));
`ifdef BTN_RELEASE_PULSE_EN
    checkOutput("release", 32'(o_release), 32'(expRelease));
`endif
    for (int i = 0; i < N_BTN; i++) begin
      if (o_pulse[i] === 1'b1) begin
        pulseCount[i]++;
        if (firstPulse[i] < 0) firstPulse[i] = cycleCnt;
      end
`ifdef BTN_RELEASE_PULSE_EN
      if (o_release[i] === 1'b1 && firstRelease[i] < 0) firstRelease[i] = cycleCnt;
`endif
      if (prevLevel[i] === 1'b1 && o_level[i] === 1'b0 && fallEdge[i] < 0) fallEdge[i] = cycleCnt;
    end
    prevLevel = o_level;
  endtask

  // Drive inputs on the falling edge, advance the model on the rising edge,
  // then compare on the next falling edge
  task automatic applyStimulus(input logic [N_BTN-1:0] btn, input logic rst, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      i_btn = btn;
      i_reset = rst;
      @(posedge i_clk);
      modelStep();
      cycleCnt++;
      @(negedge i_clk);
      observe();
    end
  endtask

  initial begin
    int firstSample;
    int pressEdge;
    int relEdge;
    logic [N_BTN-1:0] rndBtn;
    logic rndRst;

    i_btn = '0;
    i_reset = 1'b1;
    prevLevel = '0;
    modelReset();
    clearTracking();

    // Reset held with all buttons pressed, then release reset
    applyStimulus(3'b111, 1'b1, 2);
    checkOutput("rst_level", 32'(o_level), 32'd0);
    checkOutput("rst_pulse", 32'(o_pulse), 32'd0);
    clearTracking();
    firstSample = cycleCnt + 1;
    applyStimulus(3'b111, 1'b0, 10);
    for (int i = 0; i < N_BTN; i++) begin
      checkOutput("rst_release_latency", 32'(firstPulse[i] - firstSample), 32'd5);
      checkOutput("rst_release_count", 32'(pulseCount[i]), 32'd1);
    end
    applyStimulus(3'b000, 1'b0, 10);

    // Clean press on channel 0, with channel 2 pressed two cycles later
    clearTracking();
    pressEdge = cycleCnt + 1;
    applyStimulus(3'b001, 1'b0, 2);
    applyStimulus(3'b101, 1'b0, 18);
    checkOutput("press_latency", 32'(firstPulse[0] - pressEdge), 32'd5);
    checkOutput("press_once", 32'(pulseCount[0]), 32'd1);
    checkOutput("indep_gap", 32'(firstPulse[2] - firstPulse[0]), 32'd2);
    checkOutput("held_level", 32'(o_level), 32'b101);

    // Release channel 0 while channel 2 stays held
    clearTracking();
    relEdge = cycleCnt + 1;
    applyStimulus(3'b100, 1'b0, 10);
    checkOutput("release_latency", 32'(fallEdge[0] - relEdge), 32'd5);
    checkOutput("release_no_pulse", 32'(pulseCount[0]), 32'd0);
`ifdef BTN_RELEASE_PULSE_EN
    checkOutput("release_strobe", 32'(firstRelease[0] - relEdge), 32'd5);
`endif
    applyStimulus(3'b000, 1'b0, 10);

    // Short bounce on channel 1 must be rejected
    clearTracking();
    applyStimulus(3'b010, 1'b0, 1);
    applyStimulus(3'b000, 1'b0, 1);
    applyStimulus(3'b010, 1'b0, 2);
    applyStimulus(3'b000, 1'b0, 12);
    checkOutput("bounce_pulse", 32'(pulseCount[1]), 32'd0);
    checkOutput("bounce_level", 32'(o_level[1]), 32'd0);

    // Reset while channel 0 is mid-count
    clearTracking();
    pressEdge = cycleCnt + 1;
    applyStimulus(3'b001, 1'b0, 3);
    applyStimulus(3'b001, 1'b1, 1);
    applyStimulus(3'b001, 1'b0, 10);
    checkOutput("midrst_latency", 32'(firstPulse[0] - pressEdge), 32'd9);
    checkOutput("midrst_count", 32'(pulseCount[0]), 32'd1);
    applyStimulus(3'b000, 1'b0, 10);

    // Random phase: slowly toggling buttons with occasional resets
    rndBtn = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if ($urandom_range(0, 6) == 0) rndBtn[i] = ~rndBtn[i];
      end
      rndRst = ($urandom_range(0, 249) == 0);
      applyStimulus(rndBtn, rndRst, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
